// File: rtl/alu_sequencer.sv
// alu_sequencer: control sequencer for one register-register ALU instruction.
// Ports: clock, clear (async active-high reset), start, ir[31:0] (opcode/Ra/Rb/Rc);
//        fetch strobes PCout MARin IncPC PCin Read MDRin MDRout IRin;
//        execute strobes Yin Zin Zlowout; reg_out_en/sel, reg_in_en/sel, alu_opcode;
//        status busy done illegal.
// Build option ALU_SEQ_FETCH_EN: include the T0-T2 fetch phase and latch ir at end of T2;
// otherwise ir is latched on the start edge and IDLE goes straight to T3.
module alu_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        reg_out_en,
    output logic [3:0]  reg_out_sel,
    output logic        reg_in_en,
    output logic [3:0]  reg_in_sel,
    output logic [3:0]  alu_opcode,
    output logic        busy,
    output logic        done,
    output logic        illegal
);
`ifdef ALU_SEQ_FETCH_EN
    localparam bit FETCH = 1'b1;
`else
    localparam bit FETCH = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5} state_t;
    state_t state, nxt;
    logic [3:0] op, ra, rb, rc, op_n, ra_n, rb_n, rc_n;
    logic [4:0] op_m3;
    logic legal, latch;
    logic unused_bits;
    assign unused_bits = ^{ir[14:0], op_m3[4]};
    // Legal opcodes 3..10 map linearly onto ALU codes 0..7.
    assign op_m3 = ir[31:27] - 5'd3;
    assign legal = ir[31:27] >= 5'd3 && ir[31:27] <= 5'd10;
    assign latch = FETCH ? state == T2 : state == IDLE && start;
    assign op_n = latch ? op_m3[3:0] : op;
    assign ra_n = latch ? ir[26:23] : ra;
    assign rb_n = latch ? ir[22:19] : rb;
    assign rc_n = latch ? ir[18:15] : rc;
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = !start ? IDLE : FETCH ? T0 : legal ? T3 : IDLE;
            T0:      nxt = T1;
            T1:      nxt = T2;
            T2:      nxt = legal ? T3 : IDLE;
            T3:      nxt = T4;
            T4:      nxt = T5;
            default: nxt = IDLE;
        endcase
    end
    // Outputs are registered decodes of the next state, so they line up with state.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            {op, ra, rb, rc} <= '0;
            {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin} <= '0;
            {Yin, Zin, Zlowout, reg_out_en, reg_in_en} <= '0;
            reg_out_sel <= '0;
            reg_in_sel  <= '0;
            alu_opcode  <= '0;
            {busy, done, illegal} <= '0;
        end else begin
            state       <= nxt;
            op          <= op_n;
            ra          <= ra_n;
            rb          <= rb_n;
            rc          <= rc_n;
            PCout       <= FETCH && nxt == T0;
            MARin       <= FETCH && nxt == T0;
            IncPC       <= FETCH && nxt == T0;
            PCin        <= FETCH && nxt == T1;
            Read        <= FETCH && nxt == T1;
            MDRin       <= FETCH && nxt == T1;
            MDRout      <= FETCH && nxt == T2;
            IRin        <= FETCH && nxt == T2;
            Yin         <= nxt == T3;
            Zin         <= (FETCH && nxt == T0) || nxt == T4;
            Zlowout     <= (FETCH && nxt == T1) || nxt == T5;
            reg_out_en  <= nxt == T3 || nxt == T4;
            reg_out_sel <= nxt == T3 ? rb_n : nxt == T4 ? rc_n : 4'd0;
            alu_opcode  <= nxt == T4 ? op_n : 4'd0;
            reg_in_en   <= nxt == T5;
            reg_in_sel  <= nxt == T5 ? ra_n : 4'd0;
            busy        <= nxt != IDLE;
            done        <= nxt == T5;
            illegal     <= latch && !legal;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer (either build).
module tb_alu_sequencer;
`ifdef ALU_SEQ_FETCH_EN
    localparam bit FETCH = 1'b1;
`else
    localparam bit FETCH = 1'b0;
`endif
    localparam int LATCH_EDGE = FETCH ? 4 : 1;
    localparam int T4_EDGE = FETCH ? 5 : 2;
    logic clock = 0, clear = 1, start = 0;
    logic [31:0] ir = '0;
    logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic Yin, Zin, Zlowout, reg_out_en, reg_in_en, busy, done, illegal;
    logic [3:0] reg_out_sel, reg_in_sel, alu_opcode;
    logic [27:0] obs;
    logic [27:0] q[$];
    int n_vec = 0, n_err = 0;

    alu_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .ir(ir),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .reg_out_en(reg_out_en), .reg_out_sel(reg_out_sel),
        .reg_in_en(reg_in_en), .reg_in_sel(reg_in_sel), .alu_opcode(alu_opcode),
        .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 clock = ~clock;

    assign obs = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
                  reg_out_en, reg_out_sel, reg_in_en, reg_in_sel, alu_opcode, busy, done, illegal};

    task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {legal, alu code} from the opcode table.
    function automatic logic [4:0] dec(input logic [4:0] op);
        case (op)
            5'b00011: return 5'h10;
            5'b00100: return 5'h11;
            5'b00101: return 5'h12;
            5'b00110: return 5'h13;
            5'b00111: return 5'h14;
            5'b01000: return 5'h15;
            5'b01001: return 5'h16;
            5'b01010: return 5'h17;
            default:  return 5'h00;
        endcase
    endfunction

    // Expected output word; st: 0 IDLE, 1..3 T0..T2, 4..6 T3..T5.
    function automatic logic [27:0] ew(input int st, input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [3:0] rc, input logic [3:0] alu, input logic ill);
        logic [7:0] f;
        logic yin, zin, zlo, roe, rie, dn;
        logic [3:0] ros, ris, ao;
        f = '0; yin = 0; zin = 0; zlo = 0; roe = 0; rie = 0; dn = 0; ros = '0; ris = '0; ao = '0;
        case (st)
            1: begin f = 8'b1110_0000; zin = 1; end
            2: begin f = 8'b0001_1100; zlo = 1; end
            3: f = 8'b0000_0011;
            4: begin roe = 1; ros = rb; yin = 1; end
            5: begin roe = 1; ros = rc; ao = alu; zin = 1; end
            6: begin zlo = 1; rie = 1; ris = ra; dn = 1; end
            default: ;
        endcase
        return {f, yin, zin, zlo, roe, ros, rie, ris, ao, st != 0, dn, ill};
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c);
        logic [31:0] r;
        r = $urandom;
        return {op, a, b, c, r[14:0]};
    endfunction

    task automatic issue(input string tag, input logic [31:0] w, input bit keep);
        logic [4:0] d;
        int n;
        d = dec(w[31:27]);
        if (FETCH) for (int s = 1; s <= 3; s++) q.push_back(ew(s, 0, 0, 0, 0, 0));
        if (d[4]) for (int s = 4; s <= 6; s++) q.push_back(ew(s, w[26:23], w[22:19], w[18:15], d[3:0], 0));
        else q.push_back(ew(0, 0, 0, 0, 0, 1));
        q.push_back(ew(0, 0, 0, 0, 0, 0));
        @(negedge clock);
        ir = w;
        start = 1;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
            if (!keep) start = 0;
            if (n == LATCH_EDGE) ir = $urandom;
            chk($sformatf("%s c%0d", tag, n), obs, q.pop_front());
        end
        q.delete();
    endtask

    initial begin
        #2;
        chk("reset_async", obs, '0);
        @(posedge clock);
        #1;
        chk("reset_held", obs, '0);
        clear = 0;
        issue("and_r5_r2_r3", 32'h2A918000, 0);
        issue("add_r1_r1_r1", mk(5'b00011, 1, 1, 1), 0);
        for (int o = 3; o <= 10; o++) begin
            logic [4:0] op5;
            op5 = o[4:0];
            issue($sformatf("op%0d", o), mk(op5, $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15)), 0);
        end
        issue("ill_1f", mk(5'b11111, 4, 5, 6), 0);
        issue("ill_00", mk(5'b00000, 7, 8, 9), 0);
        issue("ill_02", mk(5'b00010, 1, 2, 3), 0);
        issue("ill_0b", mk(5'b01011, 15, 14, 13), 0);
        issue("hold_a", mk(5'b00100, 3, 9, 12), 1);
        issue("hold_b", mk(5'b01001, 15, 0, 7), 1);
        issue("hold_c", mk(5'b00110, 6, 6, 6), 0);
        @(negedge clock);
        ir = mk(5'b00111, 9, 10, 11);
        start = 1;
        for (int e = 1; e <= T4_EDGE; e++) begin
            @(posedge clock);
            #1;
            start = 0;
            if (e == LATCH_EDGE) ir = $urandom;
        end
        chk("clr_pre_t4", obs, ew(5, 9, 10, 11, 4'd4, 0));
        #2;
        clear = 1;
        #1;
        chk("clr_async", obs, '0);
        @(posedge clock);
        #1;
        clear = 0;
        chk("clr_idle", obs, '0);
        @(posedge clock);
        #1;
        chk("clr_no_done", obs, '0);
        issue("after_clear", mk(5'b01010, 2, 4, 8), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
